// File: rtl/mm_weight_loader_pkg.sv
// Shared matrix-multiply definitions: datapath geometry and the loader/engine sequencing states.
package mm_weight_loader_pkg;

    localparam int MM_DATA_W  = 512;
    localparam int MM_BEATS   = 16;
    localparam int MM_WADDR_W = 13;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_LOAD = 2'd1,
        MM_FIN  = 2'd2
    } mm_state_t;

endpackage

// File: rtl/mm_weight_loader_beat_packer.sv
// Packs BEATS stream beats into one wide word; beat k lands in slice k, word_valid pulses one cycle later.
module mm_beat_packer #(
    parameter int DATA_W = 512,
    parameter int BEATS  = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      beat_valid,
    input  logic [DATA_W-1:0]         beat_data,
    output logic                      last_beat,
    output logic                      word_valid,
    output logic [DATA_W*BEATS-1:0]   word_data
);

    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]               beat_cnt;
    logic [BEATS-2:0][DATA_W-1:0]   asm_q;

    assign last_beat = beat_valid && (beat_cnt == CNT_W'(BEATS - 1));

    // The output word register is separate from asm_q, so beat 0 of the next
    // word can be absorbed while the previous word is still being written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt   <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (last_beat) begin
                word_data  <= {beat_data, asm_q};
                word_valid <= 1'b1;
                beat_cnt   <= '0;
            end else if (beat_valid) begin
                asm_q[beat_cnt] <= beat_data;
                beat_cnt        <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_weight_loader.sv
// Streams 512-bit beats into 8192-bit weight-buffer words at consecutive addresses, then pulses done.
//   state | meaning
//   IDLE  | waiting for start_valid
//   LOAD  | accepting beats, writing one word per 16 beats
//   FIN   | final write lands; done pulses, back to IDLE
module mm_weight_loader
    import mm_weight_loader_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int BEATS  = MM_BEATS,
    parameter int ADDR_W = MM_WADDR_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_valid,
    input  logic [ADDR_W-1:0]         weight_start_addr,
    input  logic [ADDR_W:0]           weight_word_count,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wbuf_wr_en,
    output logic [ADDR_W-1:0]         wbuf_wr_addr,
    output logic [DATA_W*BEATS-1:0]   wbuf_wr_data,
    output logic                      busy,
    output logic                      done
);

    mm_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    remaining_q;
    logic               beat_fire;
    logic               last_beat;
    logic               word_valid;
    logic               start_fire;

    assign beat_fire  = in_valid && in_ready;
    assign start_fire = (state_q == MM_IDLE) && start_valid;

    mm_beat_packer #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .beat_valid (beat_fire),
        .beat_data  (in_data),
        .last_beat  (last_beat),
        .word_valid (word_valid),
        .word_data  (wbuf_wr_data)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            MM_IDLE: begin
                if (start_valid) begin
                    state_d = (weight_word_count == '0) ? MM_FIN : MM_LOAD;
                end
            end
            MM_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_beat && (remaining_q == (ADDR_W+1)'(1))) begin
                    state_d = MM_FIN;
                end
            end
            MM_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = MM_IDLE;
            end
            default: state_d = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= MM_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_fire) begin
                addr_q      <= weight_start_addr;
                remaining_q <= weight_word_count;
            end else begin
                if (word_valid) begin
                    addr_q <= addr_q + 1'b1;
                end
                if (last_beat) begin
                    remaining_q <= remaining_q - 1'b1;
                end
            end
        end
    end

    assign wbuf_wr_en   = word_valid;
    assign wbuf_wr_addr = addr_q;

endmodule
